// File: rtl/asip_pkg.sv
// Shared types and sizing for the vector ASIP pipeline stages.
package asip_pkg;

  localparam int DATA_SIZE = 8;
  localparam int LANES     = 4;
  localparam int ADDR_SIZE = 16;
  localparam int LANE_W    = DATA_SIZE;

  typedef enum logic [1:0] {IDLE, XFER, DRAIN, RESP} mem_state_t;

  typedef enum logic [1:0] {OP_ALU, OP_LOAD, OP_STORE} op_kind_t;

endpackage

// File: rtl/mem_stage_if.sv
// EX/MEM bundle, byte-wide data-memory port and write-back bundle of the memory stage.
interface mem_stage_if
  import asip_pkg::*;
#(
  parameter int dataSize = LANE_W,
  parameter int lanes    = LANES,
  parameter int addrSize = ADDR_SIZE
);

  logic                      valid_in;
  logic                      mem_read;
  logic                      mem_write;
  logic                      vector_op;
  logic [3:0]                rd_in;
  logic [addrSize-1:0]       addr_in;
  logic [lanes*dataSize-1:0] alu_result;
  logic [lanes*dataSize-1:0] store_data;
  logic                      neg_in;
  logic                      zero_in;
  logic                      stall;

  logic [addrSize-1:0]       dmem_addr;
  logic [dataSize-1:0]       dmem_wdata;
  logic                      dmem_we;
  logic                      dmem_re;
  logic [dataSize-1:0]       dmem_rdata;

  logic                      wb_valid;
  logic                      wb_we;
  logic [3:0]                wb_rd;
  logic [lanes*dataSize-1:0] wb_data;
  logic                      wb_neg;
  logic                      wb_zero;

  modport slave (
    input  valid_in, mem_read, mem_write, vector_op, rd_in, addr_in,
           alu_result, store_data, neg_in, zero_in, dmem_rdata,
    output stall, dmem_addr, dmem_wdata, dmem_we, dmem_re,
           wb_valid, wb_we, wb_rd, wb_data, wb_neg, wb_zero
  );

  modport master (
    output valid_in, mem_read, mem_write, vector_op, rd_in, addr_in,
           alu_result, store_data, neg_in, zero_in, dmem_rdata,
    input  stall, dmem_addr, dmem_wdata, dmem_we, dmem_re,
           wb_valid, wb_we, wb_rd, wb_data, wb_neg, wb_zero
  );

endinterface

// File: rtl/mem_stage.sv
// Memory stage: scalar/vector byte-serial loads and stores, registered write-back pulse.
// Latency ALU 1, store N+1, load N+2 cycles; stall holds upstream through XFER/DRAIN.
module mem_stage
  import asip_pkg::*;
#(
  parameter int dataSize = LANE_W,
  parameter int lanes    = LANES,
  parameter int addrSize = ADDR_SIZE
) (
  input logic        clk,
  input logic        reset,
  mem_stage_if.slave mif
);

  localparam int CNT_W = $clog2(lanes) + 1;
  localparam int VEC_W = lanes * dataSize;
  localparam logic [CNT_W-1:0]    ONE      = CNT_W'(1);
  localparam logic [CNT_W-1:0]    N_VEC    = CNT_W'(lanes);
  localparam logic [addrSize-1:0] ADDR_ONE = addrSize'(1);

  mem_state_t          state, state_nx;
  op_kind_t            op, op_nx;
  logic [CNT_W-1:0]    beat, beat_nx;
  logic [CNT_W-1:0]    n_beats, n_beats_nx;
  logic [3:0]          rd_q, rd_nx;
  logic [VEC_W-1:0]    st_buf, st_nx;
  logic [VEC_W-1:0]    ld_buf, ld_nx;
  logic                rd_pend;
  logic [CNT_W-1:0]    cap_idx;

  logic [addrSize-1:0] addr_q, addr_nx;
  logic [dataSize-1:0] wdata_q, wdata_nx;
  logic                we_q, we_nx;
  logic                re_q, re_nx;
  logic                wb_valid_q, wb_valid_nx;
  logic                wb_we_q, wb_we_nx;
  logic [3:0]          wb_rd_q, wb_rd_nx;
  logic [VEC_W-1:0]    wb_data_q, wb_data_nx;
  logic                wb_neg_q, wb_neg_nx;
  logic                wb_zero_q, wb_zero_nx;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      op         <= OP_ALU;
      beat       <= '0;
      n_beats    <= '0;
      rd_q       <= '0;
      st_buf     <= '0;
      ld_buf     <= '0;
      rd_pend    <= 1'b0;
      cap_idx    <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      we_q       <= 1'b0;
      re_q       <= 1'b0;
      wb_valid_q <= 1'b0;
      wb_we_q    <= 1'b0;
      wb_rd_q    <= '0;
      wb_data_q  <= '0;
      wb_neg_q   <= 1'b0;
      wb_zero_q  <= 1'b0;
    end else begin
      state      <= state_nx;
      op         <= op_nx;
      beat       <= beat_nx;
      n_beats    <= n_beats_nx;
      rd_q       <= rd_nx;
      st_buf     <= st_nx;
      ld_buf     <= ld_nx;
      // Read data returns one cycle after the strobe; remember which lane it belongs to.
      rd_pend    <= re_q;
      cap_idx    <= beat;
      addr_q     <= addr_nx;
      wdata_q    <= wdata_nx;
      we_q       <= we_nx;
      re_q       <= re_nx;
      wb_valid_q <= wb_valid_nx;
      wb_we_q    <= wb_we_nx;
      wb_rd_q    <= wb_rd_nx;
      wb_data_q  <= wb_data_nx;
      wb_neg_q   <= wb_neg_nx;
      wb_zero_q  <= wb_zero_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    op_nx       = op;
    beat_nx     = beat;
    n_beats_nx  = n_beats;
    rd_nx       = rd_q;
    st_nx       = st_buf;
    ld_nx       = ld_buf;
    addr_nx     = addr_q;
    wdata_nx    = wdata_q;
    we_nx       = 1'b0;
    re_nx       = 1'b0;
    wb_valid_nx = 1'b0;
    wb_we_nx    = wb_we_q;
    wb_rd_nx    = wb_rd_q;
    wb_data_nx  = wb_data_q;
    wb_neg_nx   = wb_neg_q;
    wb_zero_nx  = wb_zero_q;

    if (rd_pend) begin
      ld_nx[int'(cap_idx)*dataSize +: dataSize] = mif.dmem_rdata;
    end

    case (state)
      XFER: begin
        if (beat == n_beats - ONE) begin
          if (op == OP_STORE) begin
            state_nx    = RESP;
            wb_valid_nx = 1'b1;
            wb_we_nx    = 1'b0;
            wb_rd_nx    = rd_q;
            wb_data_nx  = '0;
            wb_neg_nx   = 1'b0;
            wb_zero_nx  = 1'b0;
          end else begin
            state_nx = DRAIN;
          end
        end else begin
          beat_nx = beat + ONE;
          addr_nx = addr_q + ADDR_ONE;
          if (op == OP_STORE) begin
            we_nx    = 1'b1;
            wdata_nx = st_buf[int'(beat_nx)*dataSize +: dataSize];
          end else begin
            re_nx = 1'b1;
          end
        end
      end

      DRAIN: begin
        state_nx    = RESP;
        wb_valid_nx = 1'b1;
        wb_we_nx    = 1'b1;
        wb_rd_nx    = rd_q;
        wb_data_nx  = ld_nx;
        wb_neg_nx   = 1'b0;
        wb_zero_nx  = (ld_nx == '0);
      end

      // IDLE and RESP both accept a new bundle.
      default: begin
        state_nx = IDLE;
        if (mif.valid_in) begin
          rd_nx = mif.rd_in;
          if (mif.mem_write || mif.mem_read) begin
            op_nx      = mif.mem_write ? OP_STORE : OP_LOAD;
            n_beats_nx = mif.vector_op ? N_VEC : ONE;
            beat_nx    = '0;
            addr_nx    = mif.addr_in;
            st_nx      = mif.store_data;
            ld_nx      = '0;
            state_nx   = XFER;
            if (mif.mem_write) begin
              we_nx    = 1'b1;
              wdata_nx = mif.store_data[dataSize-1:0];
            end else begin
              re_nx = 1'b1;
            end
          end else begin
            op_nx       = OP_ALU;
            state_nx    = RESP;
            wb_valid_nx = 1'b1;
            wb_we_nx    = 1'b1;
            wb_rd_nx    = mif.rd_in;
            wb_data_nx  = mif.alu_result;
            wb_neg_nx   = mif.neg_in;
            wb_zero_nx  = mif.zero_in;
          end
        end
      end
    endcase
  end

  assign mif.stall      = (state == XFER) || (state == DRAIN);
  assign mif.dmem_addr  = addr_q;
  assign mif.dmem_wdata = wdata_q;
  assign mif.dmem_we    = we_q;
  assign mif.dmem_re    = re_q;
  assign mif.wb_valid   = wb_valid_q;
  assign mif.wb_we      = wb_we_q;
  assign mif.wb_rd      = wb_rd_q;
  assign mif.wb_data    = wb_data_q;
  assign mif.wb_neg     = wb_neg_q;
  assign mif.wb_zero    = wb_zero_q;

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: directed cases then random ops against a byte-array model.
module tb_mem_stage;

  logic clk;
  logic reset;
  int   cyc;
  int   checks;
  int   failures;
  int   st_lo;
  int   st_hi;

  typedef struct {
    logic        is_store;
    logic        we;
    logic [3:0]  rd;
    logic [31:0] data;
    logic        neg;
    logic        zero;
    int          cyc;
  } wb_exp_t;

  typedef struct {
    logic [15:0] addr;
    logic [7:0]  data;
    int          cyc;
  } mem_exp_t;

  wb_exp_t  wb_q[$];
  mem_exp_t wr_q[$];
  mem_exp_t rdq[$];

  logic [7:0] dev_mem [0:65535];
  logic [7:0] ref_mem [0:65535];

  mem_stage_if #(.dataSize(8), .lanes(4), .addrSize(16)) mif ();

  mem_stage #(.dataSize(8), .lanes(4), .addrSize(16)) dut (
    .clk   (clk),
    .reset (reset),
    .mif   (mif)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Data memory: read data is returned one cycle after the read strobe.
  always @(posedge clk) begin
    if (mif.dmem_we) dev_mem[mif.dmem_addr] = mif.dmem_wdata;
    if (mif.dmem_re) mif.dmem_rdata <= dev_mem[mif.dmem_addr];
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    mem_exp_t e;
    wb_exp_t  w;
    chk("stall", mif.stall, (cyc >= st_lo && cyc <= st_hi));
    if (mif.dmem_we) begin
      if (wr_q.size() == 0) chk("unexpected_we", mif.dmem_we, 1'b0);
      else begin
        e = wr_q.pop_front();
        chk("wr_addr", mif.dmem_addr, e.addr);
        chk("wr_data", mif.dmem_wdata, e.data);
        chk("wr_cycle", cyc, e.cyc);
      end
    end
    if (mif.dmem_re) begin
      if (rdq.size() == 0) chk("unexpected_re", mif.dmem_re, 1'b0);
      else begin
        e = rdq.pop_front();
        chk("rd_addr", mif.dmem_addr, e.addr);
        chk("rd_cycle", cyc, e.cyc);
      end
    end
    if (mif.wb_valid) begin
      if (wb_q.size() == 0) chk("unexpected_wb", mif.wb_valid, 1'b0);
      else begin
        w = wb_q.pop_front();
        chk("wb_cycle", cyc, w.cyc);
        chk("wb_we", mif.wb_we, w.we);
        if (!w.is_store) begin
          chk("wb_rd", mif.wb_rd, w.rd);
          chk("wb_data", mif.wb_data, w.data);
          chk("wb_neg", mif.wb_neg, w.neg);
          chk("wb_zero", mif.wb_zero, w.zero);
        end
      end
    end
  end

  // Presents a bundle and holds it until a cycle where stall is low; t is the accept cycle.
  task automatic present(input logic rd_b, input logic wr_b, input logic vec,
                         input logic [3:0] rd, input logic [15:0] addr,
                         input logic [31:0] alu, input logic [31:0] sd,
                         input logic ng, input logic zr, output int t);
    logic s;
    bit   done;
    @(negedge clk);
    mif.valid_in   = 1'b1;
    mif.mem_read   = rd_b;
    mif.mem_write  = wr_b;
    mif.vector_op  = vec;
    mif.rd_in      = rd;
    mif.addr_in    = addr;
    mif.alu_result = alu;
    mif.store_data = sd;
    mif.neg_in     = ng;
    mif.zero_in    = zr;
    done = 1'b0;
    t = 0;
    for (int k = 0; k < 64 && !done; k++) begin
      s = mif.stall;
      t = cyc;
      @(posedge clk);
      if (!s) done = 1'b1;
      else @(negedge clk);
    end
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout actual=stalled required=accepted (cycle %0d)", cyc);
    end
  endtask

  // Reference model: expected beats and write-back derived from op rules and a byte array.
  task automatic do_op(input logic rd_b, input logic wr_b, input logic vec,
                       input logic [3:0] rd, input logic [15:0] addr,
                       input logic [31:0] alu, input logic [31:0] sd,
                       input logic ng, input logic zr);
    int          t;
    int          n;
    logic [15:0] a;
    logic [31:0] d;
    present(rd_b, wr_b, vec, rd, addr, alu, sd, ng, zr, t);
    n = vec ? 4 : 1;
    d = '0;
    if (wr_b) begin
      for (int i = 0; i < n; i++) begin
        a = addr + 16'(i);
        wr_q.push_back('{a, sd[i*8 +: 8], t + 1 + i});
        ref_mem[a] = sd[i*8 +: 8];
      end
      st_lo = t + 1;
      st_hi = t + n;
      wb_q.push_back('{1'b1, 1'b0, rd, 32'h0, 1'b0, 1'b0, t + n + 1});
    end else if (rd_b) begin
      for (int i = 0; i < n; i++) begin
        a = addr + 16'(i);
        rdq.push_back('{a, 8'h00, t + 1 + i});
        d[i*8 +: 8] = ref_mem[a];
      end
      st_lo = t + 1;
      st_hi = t + n + 1;
      wb_q.push_back('{1'b0, 1'b1, rd, d, 1'b0, (d == 32'h0), t + n + 2});
    end else begin
      st_lo = 1;
      st_hi = 0;
      wb_q.push_back('{1'b0, 1'b1, rd, alu, ng, zr, t + 1});
    end
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    mif.valid_in = 1'b0;
    for (int i = 1; i < n; i++) @(negedge clk);
  endtask

  initial begin
    int          t;
    logic [31:0] sd;
    logic [15:0] a;
    checks   = 0;
    failures = 0;
    st_lo    = 1;
    st_hi    = 0;
    reset    = 1'b1;
    mif.valid_in   = 1'b0;
    mif.mem_read   = 1'b0;
    mif.mem_write  = 1'b0;
    mif.vector_op  = 1'b0;
    mif.rd_in      = '0;
    mif.addr_in    = '0;
    mif.alu_result = '0;
    mif.store_data = '0;
    mif.neg_in     = 1'b0;
    mif.zero_in    = 1'b0;
    for (int i = 0; i < 65536; i++) begin
      dev_mem[i] = 8'($urandom);
      ref_mem[i] = dev_mem[i];
    end
    for (int i = 0; i < 4; i++) begin
      dev_mem[16'h0020 + i] = 8'(i + 1);
      ref_mem[16'h0020 + i] = 8'(i + 1);
    end
    dev_mem[0] = 8'h00;
    ref_mem[0] = 8'h00;

    repeat (3) @(negedge clk);
    chk("rst_stall", mif.stall, 1'b0);
    chk("rst_dmem_we", mif.dmem_we, 1'b0);
    chk("rst_dmem_re", mif.dmem_re, 1'b0);
    chk("rst_dmem_addr", mif.dmem_addr, 16'h0);
    chk("rst_dmem_wdata", mif.dmem_wdata, 8'h0);
    chk("rst_wb_valid", mif.wb_valid, 1'b0);
    chk("rst_wb_we", mif.wb_we, 1'b0);
    chk("rst_wb_rd", mif.wb_rd, 4'h0);
    chk("rst_wb_data", mif.wb_data, 32'h0);
    chk("rst_wb_neg", mif.wb_neg, 1'b0);
    chk("rst_wb_zero", mif.wb_zero, 1'b0);
    reset = 1'b0;

    do_op(1'b0, 1'b0, 1'b0, 4'd3, 16'h0000, 32'h11223344, 32'h0, 1'b0, 1'b0);
    do_op(1'b0, 1'b1, 1'b1, 4'd1, 16'h0010, 32'h0, 32'hDDCCBBAA, 1'b0, 1'b0);
    do_op(1'b1, 1'b0, 1'b1, 4'd2, 16'h0020, 32'h0, 32'h0, 1'b0, 1'b0);
    idle(2);
    do_op(1'b1, 1'b0, 1'b0, 4'd4, 16'h0000, 32'h0, 32'h0, 1'b0, 1'b0);
    do_op(1'b1, 1'b0, 1'b1, 4'd6, 16'hFFFE, 32'h0, 32'h0, 1'b0, 1'b0);
    do_op(1'b1, 1'b1, 1'b0, 4'd7, 16'h0010, 32'h0, 32'h00000055, 1'b0, 1'b0);
    do_op(1'b0, 1'b0, 1'b1, 4'd8, 16'h0000, 32'h80000000, 32'h0, 1'b1, 1'b0);
    idle(3);

    // Abort a vector store after two beats.
    sd = $urandom;
    present(1'b0, 1'b1, 1'b1, 4'd5, 16'h0100, 32'h0, sd, 1'b0, 1'b0, t);
    for (int i = 0; i < 2; i++) begin
      a = 16'h0100 + 16'(i);
      wr_q.push_back('{a, sd[i*8 +: 8], t + 1 + i});
      ref_mem[a] = sd[i*8 +: 8];
    end
    st_lo = t + 1;
    st_hi = t + 2;
    @(negedge clk);
    mif.valid_in = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_dmem_we", mif.dmem_we, 1'b0);
    chk("abort_wb_valid", mif.wb_valid, 1'b0);
    chk("abort_stall", mif.stall, 1'b0);
    do_op(1'b1, 1'b0, 1'b1, 4'd9, 16'h0100, 32'h0, 32'h0, 1'b0, 1'b0);

    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 3))
        0:       a = 16'hFFFC + 16'($urandom_range(0, 3));
        default: a = 16'h0200 + 16'($urandom_range(0, 15));
      endcase
      do_op(1'($urandom), 1'($urandom), 1'($urandom), 4'($urandom), a,
            $urandom, $urandom, 1'($urandom), 1'($urandom));
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
    end
    idle(1);

    for (int k = 0; k < 40 && (wb_q.size() + wr_q.size() + rdq.size()) != 0; k++)
      @(negedge clk);
    chk("wb_outstanding", 32'(wb_q.size()), 32'd0);
    chk("wr_outstanding", 32'(wr_q.size()), 32'd0);
    chk("rd_outstanding", 32'(rdq.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory stage of the vector ASIP pipeline, directly downstream of the execute-stage ALU. Takes the registered EX/MEM bundle (ALU result, flags, address, store vector, control) and performs scalar or vector loads/stores against a byte-wide, single-port data memory, one lane per cycle. Stalls the upstream pipeline for the duration of a memory transfer. Presents a registered write-back bundle with a one-cycle `wb_valid` pulse.

## Interface
- `dataSize`, 8: lane width in bits; matches the ALU.
- `lanes`, 4: lanes per vector.
- `addrSize`, 16: data memory address width.

- `clk`  in  1  rising-edge clock
- `reset`  in  1  synchronous, active-high reset
- `valid_in`  in  1  EX/MEM bundle valid
- `mem_read`  in  1  load op
- `mem_write`  in  1  store op; wins if both set
- `vector_op`  in  1  1 = `lanes` beats, 0 = single beat (lane 0)
- `rd_in`  in  4  destination register tag
- `addr_in`  in  addrSize  base address
- `alu_result`  in  lanes*dataSize  ALU result vector
- `store_data`  in  lanes*dataSize  store vector; lane i = bits [i*dataSize +: dataSize]
- `neg_in`, `zero_in`  in  1 each  ALU flags
- `stall`  out  1  upstream must hold its bundle
- `dmem_addr`  out  addrSize  memory address
- `dmem_wdata`  out  dataSize  write byte
- `dmem_we`, `dmem_re`  out  1 each  write/read strobes
- `dmem_rdata`  in  dataSize  read data; valid the cycle after `dmem_re`
- `wb_valid`  out  1  one-cycle write-back pulse
- `wb_we`  out  1  register write enable (0 for stores)
- `wb_rd`  out  4  destination tag
- `wb_data`  out  lanes*dataSize  write-back vector
- `wb_neg`, `wb_zero`  out  1 each  flags to write back

## Operation
- FSM states: IDLE, XFER, DRAIN, RESP.
- IDLE: bundle accepted when `valid_in`. Latch `rd_in`, `addr_in`, `store_data`, op kind; set N = `vector_op ? lanes : 1`; beat counter = 0.
  - Non-memory op: go to RESP with `wb_data`=`alu_result`, flags passed through, `wb_we`=1.
  - Memory op: go to XFER.
- XFER, beat i: `dmem_addr` = base + i mod 2^addrSize.
  - Store: `dmem_we`=1, `dmem_wdata` = latched lane i.
  - Load: `dmem_re`=1.
  - On last beat (i = N-1): store → RESP, load → DRAIN.
- Load capture: `dmem_rdata` is written into lane i the cycle after beat i, in XFER or DRAIN. Unused lanes of a scalar load are 0.
- DRAIN: captures the final byte, then goes to RESP.
- RESP:
  - `wb_valid`=1 for exactly one cycle.
  - Store: `wb_we`=0.
  - Load: `wb_we`=1, `wb_neg`=0, `wb_zero` = (`wb_data`==0).
  - RESP also behaves as IDLE: it can accept a new bundle in the same cycle.
- `stall` = state ∈ {XFER, DRAIN}.
- `valid_in` is ignored while stalled. The held bundle is re-presented and accepted once the FSM reaches RESP.
- Reset forces IDLE in any state and aborts any transfer in progress; no strobe is asserted the following cycle.
- Reset values of all outputs: `stall`=0, `dmem_we`=0, `dmem_re`=0, `dmem_addr`=0, `dmem_wdata`=0, `wb_valid`=0, `wb_we`=0, `wb_rd`=0, `wb_data`=0, `wb_neg`=0, `wb_zero`=0.

## Timing
- Bundle accepted at cycle T.
- Non-memory op: `wb_valid` at T+1. No stall.
- Store: beats at T+1..T+N; `wb_valid` at T+N+1; `stall` high T+1..T+N.
- Load: beats at T+1..T+N; DRAIN at T+N+1; `wb_valid` at T+N+2; `stall` high T+1..T+N+1.
- Back-to-back bundles are supported: the cycle after a `wb_valid` can carry the next op's first beat.
- Memory strobes, address and write data are registered outputs. `stall` is decoded from state.
- Address wrap: base 16'hFFFE with a vector op uses addresses FFFE, FFFF, 0000, 0001.

## Structure
- Shared package `asip_pkg` holds:
  - `mem_state_t` enum (IDLE, XFER, DRAIN, RESP);
  - the lane-slice helper constant LANE_W = dataSize.
- Single module, no sub-module. The beat counter and lane capture register are too small to split out.

## Test plan
- ALU op: `alu_result`=32'h11223344, `rd_in`=3, `zero_in`=0 → `wb_valid` at T+1, `wb_data`=32'h11223344, `wb_we`=1, `stall` never high.
- Vector store: base 16'h0010, `store_data`=32'hDDCCBBAA → writes AA@0010, BB@0011, CC@0012, DD@0013 at T+1..T+4; `wb_valid` at T+5 with `wb_we`=0.
- Vector load: memory model returns 01,02,03,04 from 0x20..0x23 → `wb_data`=32'h04030201 at T+6; `wb_zero`=0; `stall` high T+1..T+5.
- Scalar load of 0x00 → `wb_data`=0, `wb_zero`=1, `wb_valid` at T+3.
- Wrap: vector load from 16'hFFFE → `dmem_addr` sequence FFFE, FFFF, 0000, 0001.
- Reset asserted at T+2 of a vector store → `dmem_we`=0 from T+3; no `wb_valid`; a new bundle at T+4 is accepted normally.
